cache_mem_arbiter: RTL and testbench

Downstream neighbour of the pipelined I-cache and D-cache controllers. It accepts 256-bit cacheline read/write requests from both caches, arbitrates them onto a single physical-memory port, and converts each line transfer into a 4-beat, 64-bit burst. It returns a one-cycle `*_pmem_resp` pulse to the requesting cache, with read data valid in that cycle.

---
 rtl/cache_mux_types.sv | 26 ++
 rtl/burst_line_buffer.sv | 45 ++++
 rtl/cache_mem_arbiter.sv | 106 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mux_types.sv
// Shared types and constants for the cache-to-memory arbiter slice.
package cache_mux_types;

  localparam int LINE_WIDTH  = 256;
  localparam int BEAT_WIDTH  = 64;
  localparam int BURST_BEATS = 4;
  localparam int BEAT_IDX_W  = $clog2(BURST_BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BURST_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    RESP_I,
    RESP_D
  } arb_state_t;

  // Line-aligned base address: byte offset within the line cleared.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], OFFSET_BITS'(0)};
  endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// 256-bit line buffer with a beat counter; assembles read bursts and
// serialises write-back lines one 64-bit beat at a time.
module burst_line_buffer
  import cache_mux_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_beat,
  input  logic                  advance,
  input  logic                  load_line,
  input  logic [LINE_WIDTH-1:0] line_in,
  input  logic                  write_beat,
  input  logic [BEAT_WIDTH-1:0] beat_in,
  output logic [BEAT_IDX_W-1:0] beat_sel,
  output logic [BEAT_WIDTH-1:0] beat_out,
  output logic [LINE_WIDTH-1:0] line_out
);

  logic [LINE_WIDTH-1:0] line_q;
  logic [BEAT_IDX_W-1:0] beat_q;

  // NOTE: the wide line register is reset on purpose so both rdata ports read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      beat_q <= '0;
    end else begin
      if (load_line) begin
        line_q <= line_in;
      end else if (write_beat) begin
        line_q[int'(beat_q)*BEAT_WIDTH +: BEAT_WIDTH] <= beat_in;
      end
      if (clear_beat) begin
        beat_q <= '0;
      end else if (advance) begin
        beat_q <= beat_q + BEAT_IDX_W'(1);
      end
    end
  end

  assign beat_sel = beat_q;
  assign beat_out = line_q[int'(beat_q)*BEAT_WIDTH +: BEAT_WIDTH];
  assign line_out = line_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one 64-bit burst memory
// port; alternates grants when both sides are pending.
module cache_mem_arbiter
  import cache_mux_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [31:0]           i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [31:0]           d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_address,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t            state, next_state;
  logic                  last_d;
  logic [31:0]           addr_q;
  logic [BEAT_IDX_W-1:0] beat;
  logic [BEAT_WIDTH-1:0] beat_word;
  logic [LINE_WIDTH-1:0] line;
  logic                  d_req, i_req, in_read, in_burst, last_resp, grant;

  assign d_req     = d_pmem_read | d_pmem_write;
  assign i_req     = i_pmem_read;
  assign in_read   = (state == I_READ) || (state == D_READ);
  assign in_burst  = in_read || (state == D_WRITE);
  assign last_resp = in_burst && mem_resp && (beat == LAST_BEAT);
  assign grant     = (state == IDLE) && (next_state != IDLE);

  // NOTE: registers take non-blocking assignments; the always_comb below uses blocking ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state is defaulted before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        // D wins unless I is also pending and D was the side served last.
        if (d_req && (!i_req || !last_d)) begin
          next_state = d_pmem_write ? D_WRITE : D_READ;
        end else if (i_req) begin
          next_state = I_READ;
        end
      end
      I_READ:          if (last_resp) next_state = RESP_I;
      D_READ, D_WRITE: if (last_resp) next_state = RESP_D;
      RESP_I, RESP_D:  next_state = IDLE;
      default:         next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      last_d <= 1'b0;
    end else begin
      if (grant) begin
        addr_q <= line_base((next_state == I_READ) ? i_pmem_address : d_pmem_address);
      end
      if (last_resp) begin
        last_d <= (state != I_READ);
      end
    end
  end

  burst_line_buffer u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .clear_beat (grant),
    .advance    (in_burst && mem_resp),
    .load_line  (grant && (next_state == D_WRITE)),
    .line_in    (d_pmem_wdata),
    .write_beat (in_read && mem_resp),
    .beat_in    (mem_rdata),
    .beat_sel   (beat),
    .beat_out   (beat_word),
    .line_out   (line)
  );

  assign mem_read     = in_read;
  assign mem_write    = (state == D_WRITE);
  assign mem_address  = addr_q;
  assign mem_wdata    = mem_write ? beat_word : '0;
  assign i_pmem_resp  = (state == RESP_I);
  assign d_pmem_resp  = (state == RESP_D);
  assign i_pmem_rdata = line;
  assign d_pmem_rdata = line;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised bench for cache_mem_arbiter: a cycle-level memory responder plus
// a transaction-level model of grant order, burst contents and line data.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  cache_mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
  } burst_t;

  int vectors = 0;
  int miscompares = 0;

  burst_t       burst_q[$];
  logic [255:0] iresp_q[$];
  logic [255:0] dresp_q[$];
  logic [63:0]  wr_q[$];
  burst_t       cur;
  int           stable_errs, pulse_errs, burst_cycles, last_burst_cycles;
  int           mem_wait, beat_wait, wait_cnt, beat_cnt;
  bit           prev_active, prev_iresp, prev_dresp;
  bit           fixed_pattern, stray_mode, rand_wait, model_last_d;
  logic [31:0]  salt;

  // Memory contents as a pure function of line address and beat number.
  function automatic logic [63:0] word_for(input logic [31:0] addr, input int beat);
    if (fixed_pattern) return 64'h1111_1111_1111_1111 * 64'(beat + 1);
    return {addr ^ salt, salt + 32'(beat) * 32'h0101_0101};
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] base);
    logic [255:0] l;
    for (int b = 0; b < 4; b++) l[b*64 +: 64] = word_for(base, b);
    return l;
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic pick_wait();
    beat_wait = rand_wait ? int'($urandom_range(0, 3)) : mem_wait;
  endtask

  // One clock of cache + memory behaviour, evaluated at the falling edge.
  task automatic step();
    bit     active;
    burst_t now;
    @(negedge clk);
    active = mem_read || mem_write;
    now    = '{rd: mem_read, wr: mem_write, addr: mem_address};
    if (active && !prev_active) begin
      burst_q.push_back(now);
      cur = now; beat_cnt = 0; wait_cnt = 0; burst_cycles = 0;
      pick_wait();
    end else if (active && now != cur) begin
      stable_errs++;
    end
    if (active) burst_cycles++;
    else if (prev_active) last_burst_cycles = burst_cycles;
    if (i_pmem_resp) begin
      iresp_q.push_back(i_pmem_rdata);
      i_pmem_read = 1'b0;
      if (prev_iresp) pulse_errs++;
    end
    if (d_pmem_resp) begin
      dresp_q.push_back(d_pmem_rdata);
      d_pmem_read = 1'b0;
      d_pmem_write = 1'b0;
      if (prev_dresp) pulse_errs++;
    end
    prev_iresp = i_pmem_resp;
    prev_dresp = d_pmem_resp;
    mem_resp = 1'b0;
    if (active && beat_cnt < 4) begin
      if (wait_cnt < beat_wait) begin
        wait_cnt++;
      end else begin
        mem_resp  = 1'b1;
        mem_rdata = word_for(mem_address, beat_cnt);
        if (mem_write) wr_q.push_back(mem_wdata);
        beat_cnt++;
        wait_cnt = 0;
        pick_wait();
      end
    end else if (!active && stray_mode) begin
      mem_resp  = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
    end
    prev_active = active;
  endtask

  task automatic clear_logs();
    burst_q.delete(); iresp_q.delete(); dresp_q.delete(); wr_q.delete();
    stable_errs = 0; pulse_errs = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    mem_resp = 1'b0; stray_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    prev_active = 1'b0; prev_iresp = 1'b0; prev_dresp = 1'b0;
    model_last_d = 1'b0;
  endtask

  task automatic wait_resps(input int n_i, input int n_d, input string tag);
    int budget = 400;
    while ((iresp_q.size() < n_i || dresp_q.size() < n_d) && budget > 0) begin
      step();
      budget--;
    end
    vectors++;
    if (iresp_q.size() < n_i || dresp_q.size() < n_d) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d I / %0d D resps, required %0d / %0d",
               tag, iresp_q.size(), dresp_q.size(), n_i, n_d);
    end
  endtask

  // Requests from one or both caches raised together; the model predicts the
  // grant order from the alternation rule and the data from word_for().
  task automatic run_round(input bit i_on, input bit d_on, input bit d_wr, input string tag);
    logic [31:0]  ia, da;
    logic [255:0] wl, got_line;
    burst_t       e_i, e_d, e_first, e_second, got_b;
    bit           d_first;
    int           n;
    clear_logs();
    salt = $urandom;
    ia = $urandom; da = $urandom;
    for (int k = 0; k < 8; k++) wl[k*32 +: 32] = $urandom;
    i_pmem_address = ia; d_pmem_address = da; d_pmem_wdata = wl;
    i_pmem_read  = i_on;
    d_pmem_write = d_on && d_wr;
    d_pmem_read  = d_on && (!d_wr || ($urandom_range(0, 3) == 0));
    d_first  = d_on && (!i_on || !model_last_d);
    e_i      = '{rd: 1'b1, wr: 1'b0, addr: base_of(ia)};
    e_d      = '{rd: !d_wr, wr: d_wr, addr: base_of(da)};
    e_first  = d_first ? e_d : e_i;
    e_second = d_first ? e_i : e_d;
    n = int'(i_on) + int'(d_on);
    wait_resps(int'(i_on), int'(d_on), tag);
    repeat (2) step();
    vectors++;
    if (burst_q.size() != n) begin
      miscompares++;
      $display("FAIL %s burst_count: got %0d required %0d", tag, burst_q.size(), n);
    end
    got_b = (burst_q.size() > 0) ? burst_q[0] : '0;
    vectors++;
    if (got_b !== e_first) begin
      miscompares++;
      $display("FAIL %s first_burst: got %h required %h", tag, got_b, e_first);
    end
    if (n == 2) begin
      got_b = (burst_q.size() > 1) ? burst_q[1] : '0;
      vectors++;
      if (got_b !== e_second) begin
        miscompares++;
        $display("FAIL %s second_burst: got %h required %h", tag, got_b, e_second);
      end
    end
    if (i_on) begin
      got_line = (iresp_q.size() > 0) ? iresp_q[0] : '0;
      vectors++;
      if (got_line !== exp_line(base_of(ia))) begin
        miscompares++;
        $display("FAIL %s i_rdata: got %h required %h", tag, got_line, exp_line(base_of(ia)));
      end
    end
    if (d_on && !d_wr) begin
      got_line = (dresp_q.size() > 0) ? dresp_q[0] : '0;
      vectors++;
      if (got_line !== exp_line(base_of(da))) begin
        miscompares++;
        $display("FAIL %s d_rdata: got %h required %h", tag, got_line, exp_line(base_of(da)));
      end
    end
    if (d_on && d_wr) begin
      got_line = '0;
      for (int k = 0; k < wr_q.size() && k < 4; k++) got_line[k*64 +: 64] = wr_q[k];
      vectors++;
      if (wr_q.size() != 4 || got_line !== wl) begin
        miscompares++;
        $display("FAIL %s wdata_beats: got %0d beats %h required 4 beats %h",
                 tag, wr_q.size(), got_line, wl);
      end
    end
    vectors++;
    if (stable_errs != 0 || pulse_errs != 0 || iresp_q.size() != int'(i_on)
        || dresp_q.size() != int'(d_on)) begin
      miscompares++;
      $display("FAIL %s protocol: unstable=%0d long_resp=%0d i_resps=%0d d_resps=%0d",
               tag, stable_errs, pulse_errs, iresp_q.size(), dresp_q.size());
    end
    model_last_d = (n == 2) ? !d_first : d_on;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b0;
    #1;
    vectors++;
    if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b required 0000",
               {mem_read, mem_write, i_pmem_resp, d_pmem_resp});
    end
    vectors++;
    if (mem_address !== 32'h0 || mem_wdata !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h required 0", mem_address, mem_wdata);
    end
    vectors++;
    if (i_pmem_rdata !== 256'h0 || d_pmem_rdata !== 256'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got i %h d %h required 0", i_pmem_rdata, d_pmem_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_i_read();
    int     n = 0;
    burst_t got_b;
    logic [255:0] got_line;
    clear_logs();
    fixed_pattern = 1'b1;
    i_pmem_address = 32'h0000_1234;
    i_pmem_read = 1'b1;
    while (iresp_q.size() == 0 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL i_read_latency: got resp at cycle %0d required 5", n);
    end
    repeat (3) step();
    got_b = (burst_q.size() > 0) ? burst_q[0] : '0;
    vectors++;
    if (got_b !== {1'b1, 1'b0, 32'h0000_1220}) begin
      miscompares++;
      $display("FAIL i_read_burst: got %h required %h", got_b, {1'b1, 1'b0, 32'h0000_1220});
    end
    got_line = (iresp_q.size() > 0) ? iresp_q[0] : '0;
    vectors++;
    if (got_line !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      miscompares++;
      $display("FAIL i_read_rdata: got %h required 4444..3333..2222..1111..", got_line);
    end
    vectors++;
    if (burst_q.size() != 1 || iresp_q.size() != 1 || dresp_q.size() != 0 || pulse_errs != 0) begin
      miscompares++;
      $display("FAIL i_read_once: got %0d bursts %0d I resps %0d D resps required 1/1/0",
               burst_q.size(), iresp_q.size(), dresp_q.size());
    end
    fixed_pattern = 1'b0;
    model_last_d = 1'b0;
  endtask

  task automatic test_d_write();
    run_round(1'b0, 1'b1, 1'b1, "d_write");
  endtask

  task automatic test_arbitration();
    apply_reset();
    run_round(1'b1, 1'b1, 1'b0, "arb_from_reset");
    run_round(1'b0, 1'b1, 1'b0, "arb_d_only");
    run_round(1'b1, 1'b1, 1'b0, "arb_alternate");
  endtask

  task automatic test_wait_states();
    mem_wait = 3;
    run_round(1'b1, 1'b0, 1'b0, "wait_states");
    vectors++;
    if (last_burst_cycles != 16) begin
      miscompares++;
      $display("FAIL wait_states_hold: got mem_read for %0d cycles required 16", last_burst_cycles);
    end
    mem_wait = 0;
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    clear_logs();
    salt = $urandom;
    d_pmem_address = 32'hC0DE_0100;
    d_pmem_read = 1'b1;
    do begin
      step();
      n++;
    end while (!(prev_active && beat_cnt == 2) && n < 20);
    vectors++;
    if (!(prev_active && beat_cnt == 2)) begin
      miscompares++;
      $display("FAIL mid_burst_start: got no burst within %0d cycles required beat 2", n);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; d_pmem_read = 1'b0; mem_resp = 1'b0;
    #1;
    vectors++;
    if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || mem_address !== 32'h0
        || mem_wdata !== 64'h0 || d_pmem_rdata !== 256'h0 || i_pmem_rdata !== 256'h0) begin
      miscompares++;
      $display("FAIL mid_burst_reset: got strobes %b addr %h d_rdata %h required all 0",
               {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, mem_address, d_pmem_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    prev_active = 1'b0; prev_iresp = 1'b0; prev_dresp = 1'b0;
    model_last_d = 1'b0;
    clear_logs();
    repeat (10) step();
    vectors++;
    if (burst_q.size() != 0 || iresp_q.size() != 0 || dresp_q.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %0d bursts %0d resps required 0",
               burst_q.size(), iresp_q.size() + dresp_q.size());
    end
    run_round(1'b0, 1'b1, 1'b0, "post_reset_restart");
  endtask

  task automatic test_stray_resp();
    clear_logs();
    stray_mode = 1'b1;
    repeat (20) step();
    stray_mode = 1'b0;
    mem_resp = 1'b0;
    vectors++;
    if (burst_q.size() != 0 || iresp_q.size() != 0 || dresp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stray_resp: got %0d bursts %0d I resps %0d D resps required 0",
               burst_q.size(), iresp_q.size(), dresp_q.size());
    end
    run_round(1'b1, 1'b1, 1'b0, "post_stray");
  endtask

  // Write-back, then a miss read issued right after its resp, with I pending.
  task automatic test_back_to_back();
    logic [31:0]  ia, da, da2;
    logic [255:0] wl, got_line;
    burst_t       exp_b[3];
    burst_t       got_b;
    bit           issued = 1'b0;
    int           budget = 400;
    apply_reset();
    clear_logs();
    salt = $urandom;
    ia = $urandom; da = $urandom; da2 = $urandom;
    for (int k = 0; k < 8; k++) wl[k*32 +: 32] = $urandom;
    i_pmem_address = ia; i_pmem_read = 1'b1;
    d_pmem_address = da; d_pmem_wdata = wl; d_pmem_write = 1'b1;
    while ((iresp_q.size() < 1 || dresp_q.size() < 2) && budget > 0) begin
      step();
      budget--;
      if (dresp_q.size() == 1 && !issued) begin
        issued = 1'b1;
        d_pmem_address = da2;
        d_pmem_read = 1'b1;
      end
    end
    repeat (2) step();
    exp_b[0] = '{rd: 1'b0, wr: 1'b1, addr: base_of(da)};
    exp_b[1] = '{rd: 1'b1, wr: 1'b0, addr: base_of(ia)};
    exp_b[2] = '{rd: 1'b1, wr: 1'b0, addr: base_of(da2)};
    for (int k = 0; k < 3; k++) begin
      got_b = (burst_q.size() > k) ? burst_q[k] : '0;
      vectors++;
      if (got_b !== exp_b[k]) begin
        miscompares++;
        $display("FAIL b2b_burst%0d: got %h required %h", k, got_b, exp_b[k]);
      end
    end
    got_line = (dresp_q.size() > 1) ? dresp_q[1] : '0;
    vectors++;
    if (got_line !== exp_line(base_of(da2))) begin
      miscompares++;
      $display("FAIL b2b_d_rdata: got %h required %h", got_line, exp_line(base_of(da2)));
    end
    got_line = (iresp_q.size() > 0) ? iresp_q[0] : '0;
    vectors++;
    if (got_line !== exp_line(base_of(ia))) begin
      miscompares++;
      $display("FAIL b2b_i_rdata: got %h required %h", got_line, exp_line(base_of(ia)));
    end
    got_line = '0;
    for (int k = 0; k < wr_q.size() && k < 4; k++) got_line[k*64 +: 64] = wr_q[k];
    vectors++;
    if (wr_q.size() != 4 || got_line !== wl) begin
      miscompares++;
      $display("FAIL b2b_wdata: got %0d beats %h required 4 beats %h", wr_q.size(), got_line, wl);
    end
    model_last_d = 1'b1;
  endtask

  task automatic test_random();
    bit i_on, d_on, d_wr;
    rand_wait = 1'b1;
    for (int r = 0; r < 30; r++) begin
      i_on = 1'($urandom_range(0, 1));
      d_on = i_on ? 1'($urandom_range(0, 1)) : 1'b1;
      d_wr = 1'($urandom_range(0, 1));
      run_round(i_on, d_on, d_wr, $sformatf("random%0d", r));
      if ($urandom_range(0, 3) == 0) begin
        stray_mode = 1'b1;
        repeat (3) step();
        stray_mode = 1'b0;
        mem_resp = 1'b0;
      end
    end
    rand_wait = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0; mem_rdata = '0;
    fixed_pattern = 1'b0; rand_wait = 1'b0; mem_wait = 0; beat_wait = 0;
    wait_cnt = 0; beat_cnt = 0; burst_cycles = 0; last_burst_cycles = 0;
    salt = '0; cur = '0;
    test_reset();
    test_i_read();
    test_d_write();
    test_arbitration();
    test_wait_states();
    test_reset_mid_burst();
    test_stray_resp();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
